alu_operand_stage: RTL
======================

# alu_operand_stage

Pipeline register stage directly upstream of the ALU. Captures decoded instruction fields, resolves operand forwarding from later stages, and selects register or immediate operands. Produces the registered `A`, `B` and 4-bit `alu_ctrl` the ALU consumes, plus destination tag. Single-entry valid/ready buffer with flush, so the ALU sees stable operands for as long as the downstream stage stalls.

## Interface
Parameters:
- `n`, 32, datapath width; must equal the ALU's `n`
- `SHW`, $clog2(n), shift-amount width

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: decoded instruction present
- `in_ready` out 1: stage can accept this cycle
- `in_rs1_data`, `in_rs2_data` in n: register-file read data
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 5: register indices
- `in_imm` in n: sign-extended immediate
- `in_op_class` in 2: 00 R-type, 01 I-type ALU, 10 load/store address, 11 branch
- `in_funct3` in 3, `in_funct7b5` in 1: instruction function bits
- `ex_fwd_valid` in 1, `ex_fwd_rd` in 5, `ex_fwd_data` in n: forward from ALU result stage
- `wb_fwd_valid` in 1, `wb_fwd_rd` in 5, `wb_fwd_data` in n: forward from writeback
- `flush` in 1: discard held and incoming instruction
- `out_valid` out 1, `out_ready` in 1: handshake toward ALU stage
- `A`, `B` out n: ALU operands
- `alu_ctrl` out 4: ALU control code
- `out_rd_addr` out 5, `out_rd_we` out 1: destination tag and write enable

## Operation
- ALU codes: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 set-less-than (unsigned compare in ALU).
- Decode by class: load/store → 0000; branch → 0001 (ALU `zero` gives equality); R/I-type by funct3: 000 → add, or sub when R-type and funct7b5=1; 001 → sll; 010, 011 → slt; 100 → xor; 101 → srl (funct7b5 ignored, no arithmetic shift); 110 → or; 111 → and.
- Operand resolution per source: index 0 → value 0; else `ex_fwd_valid` and `ex_fwd_rd` match → `ex_fwd_data`; else `wb_fwd_valid` and `wb_fwd_rd` match → `wb_fwd_data`; else register data. EX has priority over WB. A forward with rd=0 is never used.
- `A` = resolved rs1. `B` = `in_imm` for classes 01 and 10, resolved rs2 for 00 and 11.
- Shift ops (0101, 0110): `B` upper bits cleared, only `B[SHW-1:0]` kept (also for R-type).
- `out_rd_we` = 1 for classes 00, 01, and 10 (load writes rd); 0 for branch. Forced 0 when `in_rd_addr`=0.

## Timing
- `in_ready` = !`out_valid` | `out_ready` (combinational; bubble can always be filled).
- Accept on `in_valid` & `in_ready` & !`flush`: all outputs register on that edge; `out_valid`=1 next cycle. Latency 1 cycle.
- Forward inputs are sampled in the accept cycle only; no re-resolution while held.
- `out_valid` & !`out_ready`: `A`, `B`, `alu_ctrl`, `out_rd_addr`, `out_rd_we` hold stable.
- `out_valid` & `out_ready` & no accept: `out_valid` → 0; data outputs hold last values; `out_rd_we` → 0.
- Simultaneous drain and accept: new instruction replaces old with no bubble.
- `flush`: `out_valid` → 0 and `out_rd_we` → 0 next edge, overrides any accept. `in_ready` still follows the formula.
- `rst`: next edge `out_valid`=0, `A`=`B`=0, `alu_ctrl`=0000, `out_rd_addr`=0, `out_rd_we`=0. Reset mid-stall drops the held instruction. `rst` overrides `flush` and accept.

## Structure
- Shared package `alu_pkg`: ALU control code constants, op-class constants, register-index width (5).
- Sub-module `alu_ctrl_decode`: combinational (op_class, funct3, funct7b5) → (alu_ctrl, is_shift, rd_we).
- Forwarding mux, operand select, and output register stay in the top level.

## Test plan
- R-type add, rs1=x1 (5), rs2=x2 (7), no forwards, `out_ready`=1 → next cycle `A`=5, `B`=7, `alu_ctrl`=0000, `out_rd_we`=1, `out_valid`=1.
- R-type funct3=000, funct7b5=1 with `ex_fwd_rd`=rs1 (data 20) and `wb_fwd_rd`=rs1 (data 9) → `A`=20, `alu_ctrl`=0001. With rs1=x0 and both forwards rd=0 → `A`=0.
- I-type slli, imm=0x0000_0423 → `alu_ctrl`=0101, `B`=0x3 (only low 5 bits kept). srai (funct7b5=1) → `alu_ctrl`=0110.
- Branch with rs1=rs2=x3 → `alu_ctrl`=0001, `out_rd_we`=0. Store class → `B`=imm, `alu_ctrl`=0000.
- Stall: `out_ready`=0 for 3 cycles while `in_valid`=1 → `in_ready`=0, outputs unchanged. `out_ready`=1 → drain and accept the new instruction on the same edge.
- `flush` with `in_valid`=1 → `out_valid`=0 next cycle. Assert `rst` while `out_valid`=1 and stalled → all outputs zero next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, operand-stage op classes, register index width.
package alu_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] OPC_R      = 2'b00;
    localparam logic [1:0] OPC_I      = 2'b01;
    localparam logic [1:0] OPC_LDST   = 2'b10;
    localparam logic [1:0] OPC_BRANCH = 2'b11;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Upstream decode, forwarding and downstream ALU handshake bundle for the operand stage.
interface alu_operand_stage_if #(parameter int n = 32);
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [n-1:0]         in_rs1_data;
    logic [n-1:0]         in_rs2_data;
    logic [REG_IDX_W-1:0] in_rs1_addr;
    logic [REG_IDX_W-1:0] in_rs2_addr;
    logic [REG_IDX_W-1:0] in_rd_addr;
    logic [n-1:0]         in_imm;
    logic [1:0]           in_op_class;
    logic [2:0]           in_funct3;
    logic                 in_funct7b5;
    logic                 ex_fwd_valid;
    logic [REG_IDX_W-1:0] ex_fwd_rd;
    logic [n-1:0]         ex_fwd_data;
    logic                 wb_fwd_valid;
    logic [REG_IDX_W-1:0] wb_fwd_rd;
    logic [n-1:0]         wb_fwd_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [n-1:0]         A;
    logic [n-1:0]         B;
    logic [3:0]           alu_ctrl;
    logic [REG_IDX_W-1:0] out_rd_addr;
    logic                 out_rd_we;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_imm, in_op_class, in_funct3, in_funct7b5,
               ex_fwd_valid, ex_fwd_rd, ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
               flush, out_ready,
        input  in_ready, out_valid, A, B, alu_ctrl, out_rd_addr, out_rd_we
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_imm, in_op_class, in_funct3, in_funct7b5,
               ex_fwd_valid, ex_fwd_rd, ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
               flush, out_ready,
        output in_ready, out_valid, A, B, alu_ctrl, out_rd_addr, out_rd_we
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational op-class/funct decode to ALU control code, shift flag and class write enable.
// Latency 0; no handshake.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] op_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       is_shift,
    output logic       rd_we
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (op_class)
            OPC_LDST:   alu_ctrl = ALU_ADD;
            OPC_BRANCH: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op_class == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010,
                    3'b011:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    // no arithmetic shift in this ALU: funct7b5 is ignored here
                    3'b101:  alu_ctrl = ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

    assign is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL);
    assign rd_we    = (op_class != OPC_BRANCH);

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: forwarding, operand select, single-entry registered buffer.
// Latency 1 cycle; holds outputs stable while out_ready is low, in_ready = !out_valid | out_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int n   = 32,
    parameter int SHW = $clog2(n)
) (
    input logic                clk,
    input logic                rst,
    alu_operand_stage_if.slave bus
);

    function automatic logic [n-1:0] resolve(
        input logic [REG_IDX_W-1:0] idx,
        input logic [n-1:0]         rf_data,
        input logic                 ex_v,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [n-1:0]         ex_d,
        input logic                 wb_v,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [n-1:0]         wb_d
    );
        // idx==0 short-circuits, so a forward tagged rd=0 can never win
        if (idx == '0)                   return '0;
        else if (ex_v && ex_rd == idx)   return ex_d;
        else if (wb_v && wb_rd == idx)   return wb_d;
        else                             return rf_data;
    endfunction

    logic [3:0]   dec_ctrl;
    logic         dec_shift;
    logic         dec_we;
    logic [n-1:0] rs1_res;
    logic [n-1:0] rs2_res;
    logic [n-1:0] b_sel;
    logic [n-1:0] b_nxt;
    logic         accept;

    logic                 valid_q;
    logic [n-1:0]         a_q;
    logic [n-1:0]         b_q;
    logic [3:0]           ctrl_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 we_q;

    alu_ctrl_decode u_decode (
        .op_class (bus.in_op_class),
        .funct3   (bus.in_funct3),
        .funct7b5 (bus.in_funct7b5),
        .alu_ctrl (dec_ctrl),
        .is_shift (dec_shift),
        .rd_we    (dec_we)
    );

    always_comb begin
        rs1_res = resolve(bus.in_rs1_addr, bus.in_rs1_data,
                          bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                          bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
        rs2_res = resolve(bus.in_rs2_addr, bus.in_rs2_data,
                          bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data,
                          bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
        b_sel = (bus.in_op_class == OPC_I || bus.in_op_class == OPC_LDST) ? bus.in_imm : rs2_res;
        b_nxt = b_sel;
        if (dec_shift) begin
            b_nxt          = '0;
            b_nxt[SHW-1:0] = b_sel[SHW-1:0];
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= ALU_ADD;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= rs1_res;
            b_q     <= b_nxt;
            ctrl_q  <= dec_ctrl;
            rd_q    <= bus.in_rd_addr;
            we_q    <= dec_we && (bus.in_rd_addr != '0);
        end else if (valid_q && bus.out_ready) begin
            // drained with nothing behind it: data holds, write enable drops
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.out_rd_addr = rd_q;
    assign bus.out_rd_we   = we_q;

endmodule
